regread_arbiter: RTL

Round-robin scheduler sharing one 32-entry × 32-bit register-file read port (the `mux_32` read mux) among `NREQ` requesters, e.g. issue slots and the commit/debug path. Each cycle it grants at most one requester and drives the mux select from that requester's register index. It captures the mux output into a response register returned one cycle later, tagged with the requester ID.

---
 rtl/regread_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 41 ++++
 rtl/regread_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/regread_pkg.sv
// Shared widths and types for the register-file read arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regread_pkg;

  localparam int NREG      = 32;
  localparam int REG_IDX_W = $clog2(NREG);
  localparam int DATA_W    = 32;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0]    word_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick of one requester, searching upward from ptr with wrap.
// Latency: purely combinational.
// Backpressure: none; a zero req vector yields a zero gnt.
//
// Ports:
//   req    - request vector, one bit per requester
//   ptr    - highest-priority requester this cycle
//   gnt    - one-hot grant (or zero)
//   gnt_id - encoded index of the granted requester (0 when no grant)
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] gnt_id
);

  logic w_found;

  // Offset k walks priority order; for each k exactly one i equals
  // (ptr + k) mod NREQ, so the first hit is the round-robin winner.
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    w_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!w_found && req[i] &&
            (((int'(ptr) + k) >= NREQ) ? (int'(ptr) + k - NREQ)
                                       : (int'(ptr) + k)) == i) begin
          w_found = 1'b1;
          gnt[i]  = 1'b1;
          gnt_id  = ID_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/regread_arbiter.sv
// Round-robin sharing of one register-file read port among NREQ requesters.
// Latency: grant and rd_select combinational; response registered, 1 cycle.
// Backpressure: requesters wait on req_ready; responses cannot be stalled.
//
// Ports:
//   clock, reset        - single clock, synchronous active-high reset
//   req_valid/req_reg   - per-requester read request and 5-bit index
//   req_ready           - one-hot grant, forced to zero during reset
//   rd_select/rd_data   - select to and data from the read mux
//   wr_en/wr_reg/wr_data- write port snoop, present only with REGREAD_BYPASS_EN
//   resp_valid/id/data  - one-cycle response strobe, owner ID and value
//
// Build option: define REGREAD_BYPASS_EN to forward same-cycle write data
// into the response when the write targets the register being read.
module regread_arbiter
  import regread_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [REG_IDX_W*NREQ-1:0] req_reg,
  output logic [NREQ-1:0]           req_ready,
  output logic [REG_IDX_W-1:0]      rd_select,
  input  logic [DATA_W-1:0]         rd_data,
`ifdef REGREAD_BYPASS_EN
  input  logic                      wr_en,
  input  logic [REG_IDX_W-1:0]      wr_reg,
  input  logic [DATA_W-1:0]         wr_data,
`endif
  output logic                      resp_valid,
  output logic [ID_W-1:0]           resp_id,
  output logic [DATA_W-1:0]         resp_data
);

  logic [ID_W-1:0]   r_ptr;
  logic              r_resp_valid;
  logic [ID_W-1:0]   r_resp_id;
  word_t             r_resp_data;

  logic [NREQ-1:0]   w_req;
  logic [NREQ-1:0]   w_gnt;
  logic [ID_W-1:0]   w_gnt_id;
  logic              w_any;
  reg_idx_t          w_sel;
  logic [ID_W-1:0]   w_ptr_nxt;
  word_t             w_resp_d;

  // Masking requests in reset kills any grant issued in the reset cycle.
  assign w_req = reset ? '0 : req_valid;

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_rr_arbiter (
    .req    (w_req),
    .ptr    (r_ptr),
    .gnt    (w_gnt),
    .gnt_id (w_gnt_id)
  );

  assign w_any     = |w_gnt;
  assign req_ready = w_gnt;

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_sel = req_reg[REG_IDX_W*i +: REG_IDX_W];
      end
    end
  end

  assign rd_select = w_sel;

  assign w_ptr_nxt = (w_gnt_id == ID_W'(NREQ-1)) ? '0 : w_gnt_id + 1'b1;

  // r0 is hardwired zero; the mux value for it is never trusted.
  always_comb begin
    w_resp_d = rd_data;
`ifdef REGREAD_BYPASS_EN
    // The write commits on the same edge as this capture, so the mux still
    // shows the old value; take the in-flight write data instead.
    if (wr_en && (wr_reg == w_sel)) begin
      w_resp_d = wr_data;
    end
`endif
    if (w_sel == '0) begin
      w_resp_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_data  <= '0;
    end else begin
      r_resp_valid <= w_any;
      if (w_any) begin
        r_ptr       <= w_ptr_nxt;
        r_resp_id   <= w_gnt_id;
        r_resp_data <= w_resp_d;
      end
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_id    = r_resp_id;
  assign resp_data  = r_resp_data;

endmodule
